// File: rtl/package_settings.sv
// package_settings: shared data width plus CORDIC constants, FSM states and the arctangent table.
package package_settings;
    localparam int SIZE_DATA = 16;
    localparam int GUARD_BITS = 2;
    localparam int CORDIC_ITERATIONS = SIZE_DATA - 2;
    localparam int CORDIC_GAIN_INV = int'(0.607253 * (2.0 ** SIZE_DATA));
    localparam int CORDIC_PI = 1 << (SIZE_DATA - 1 + GUARD_BITS);
    typedef enum logic [1:0] {IDLE, ITERATE, DONE} cordic_state_t;
    // round(atan(2^-i)/pi * 2^17); the angle scale matches SIZE_DATA=16, GUARD_BITS=2
    function automatic logic signed [SIZE_DATA+GUARD_BITS-1:0] atan_tab(input int i);
        int a;
        case (i)
            0: a = 32768;
            1: a = 19344;
            2: a = 10221;
            3: a = 5188;
            4: a = 2604;
            5: a = 1303;
            6: a = 652;
            7: a = 326;
            8: a = 163;
            9: a = 81;
            10: a = 41;
            11: a = 20;
            12: a = 10;
            13: a = 5;
            14: a = 3;
            15: a = 1;
            default: a = 0;
        endcase
        return (SIZE_DATA+GUARD_BITS)'(a);
    endfunction
endpackage

// File: rtl/cordic_micro_rotation.sv
// cordic_micro_rotation: one combinational CORDIC step; neg=0 means d=+1, neg=1 means d=-1.
module cordic_micro_rotation #(
    parameter int W = 18,
    parameter int IW = 4
) (
    input  logic signed [W-1:0]  x,
    input  logic signed [W-1:0]  y,
    input  logic signed [W-1:0]  z,
    input  logic signed [W-1:0]  angle,
    input  logic        [IW-1:0] i,
    input  logic                 neg,
    output logic signed [W-1:0]  x_next,
    output logic signed [W-1:0]  y_next,
    output logic signed [W-1:0]  z_next
);
    logic signed [W-1:0] xs, ys;
    always_comb begin
        xs = x >>> i;
        ys = y >>> i;
        x_next = neg ? x - ys : x + ys;
        y_next = neg ? y + xs : y - xs;
        z_next = neg ? z - angle : z + angle;
    end
endmodule

// File: rtl/cordic_vectoring.sv
// cordic_vectoring: iterative vectoring CORDIC, (x, y) -> magnitude/phase, one micro-rotation per clock.
// Define CORDIC_GAIN_COMPENSATION_EN to scale the magnitude by 1/K (one extra cycle of latency).
module cordic_vectoring
    import package_settings::*;
#(
    parameter int ITERATIONS = CORDIC_ITERATIONS
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [SIZE_DATA-1:0] x_in,
    input  logic signed [SIZE_DATA-1:0] y_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic        [SIZE_DATA+1:0] magnitude,
    output logic signed [SIZE_DATA-1:0] phase
);
    localparam int W = SIZE_DATA + GUARD_BITS;
    localparam int IW = $clog2(SIZE_DATA);
    cordic_state_t state;
    logic [IW-1:0] i;
    logic signed [W-1:0] x, y, z, xn, yn, zn, xe, ye, angle;
`ifdef CORDIC_GAIN_COMPENSATION_EN
    localparam int PW = W + SIZE_DATA;
    logic [PW-1:0] prod;
`endif
    assign xe = {{GUARD_BITS{x_in[SIZE_DATA-1]}}, x_in};
    assign ye = {{GUARD_BITS{y_in[SIZE_DATA-1]}}, y_in};
    assign angle = atan_tab(int'(i));
    cordic_micro_rotation #(.W(W), .IW(IW)) u_rot (
        .x(x), .y(y), .z(z), .angle(angle), .i(i), .neg(y[W-1]),
        .x_next(xn), .y_next(yn), .z_next(zn)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            i <= '0;
            x <= '0;
            y <= '0;
            z <= '0;
            in_ready <= 1'b0;
            out_valid <= 1'b0;
            magnitude <= '0;
            phase <= '0;
`ifdef CORDIC_GAIN_COMPENSATION_EN
            prod <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        // +pi and -pi share one encoding in the wrapped angle register
                        x <= x_in[SIZE_DATA-1] ? -xe : xe;
                        y <= x_in[SIZE_DATA-1] ? -ye : ye;
                        z <= x_in[SIZE_DATA-1] ? W'(CORDIC_PI) : '0;
                        i <= '0;
                        in_ready <= 1'b0;
                        state <= ITERATE;
                    end
                end
                ITERATE: begin
                    x <= xn;
                    y <= yn;
                    z <= zn;
                    i <= (i == IW'(ITERATIONS - 1)) ? '0 : i + 1'b1;
                    if (i == IW'(ITERATIONS - 1)) state <= DONE;
                end
                DONE: begin
                    if (!out_valid) begin
                        // x only grows from |x|+|y|, so x==0 marks the zero vector whose z is meaningless
                        phase <= (x == '0) ? '0 : SIZE_DATA'((z + W'(1 << (GUARD_BITS - 1))) >>> GUARD_BITS);
`ifdef CORDIC_GAIN_COMPENSATION_EN
                        if (i == '0) begin
                            prod <= PW'($unsigned(x)) * PW'(CORDIC_GAIN_INV);
                            i <= IW'(1);
                        end else begin
                            magnitude <= (SIZE_DATA+2)'((prod + PW'(1 << (SIZE_DATA - 1))) >> SIZE_DATA);
                            out_valid <= 1'b1;
                            i <= '0;
                        end
`else
                        magnitude <= (SIZE_DATA+2)'(x);
                        out_valid <= 1'b1;
`endif
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cordic_vectoring.sv
// tb_cordic_vectoring: directed and randomized checks of cordic_vectoring against an atan2/hypot model.
module tb_cordic_vectoring;
    import package_settings::*;
`ifdef CORDIC_GAIN_COMPENSATION_EN
    localparam int LAT = CORDIC_ITERATIONS + 2;
    localparam int TOL_MAG = 4;
`else
    localparam int LAT = CORDIC_ITERATIONS + 1;
    localparam int TOL_MAG = 7;
`endif
    localparam real PI = 3.141592653589793;

    typedef struct {
        int mag;
        int ph;
        int ptol;
    } exp_t;

    logic clk = 0, reset = 0, in_valid = 0, out_ready = 1;
    logic signed [SIZE_DATA-1:0] x_in = '0, y_in = '0;
    logic in_ready, out_valid;
    logic [SIZE_DATA+1:0] magnitude;
    logic signed [SIZE_DATA-1:0] phase;
    int tests = 0, fails = 0;
    exp_t q[$];
    exp_t e_mon;
    real gain = 1.0;
    bit stall = 0, done = 0;
    int hold_mag, hold_ph;

    always #5 clk = ~clk;

    cordic_vectoring dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .x_in(x_in), .y_in(y_in), .out_valid(out_valid), .out_ready(out_ready),
        .magnitude(magnitude), .phase(phase)
    );

    function automatic int wrap(input int v);
        return ((v + 32768) % 65536 + 65536) % 65536 - 32768;
    endfunction

    task automatic check(input string name, input int act, input int exp, input int tol, input bit circ);
        int d;
        d = circ ? wrap(act - exp) : act - exp;
        tests++;
        if (d < -tol || d > tol) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d) at %0t", name, act, exp, tol, $time);
        end
    endtask

    function automatic exp_t model(input int xv, input int yv);
        exp_t e;
        real h;
        h = $sqrt(real'(xv) * real'(xv) + real'(yv) * real'(yv));
        e.mag = int'(h * gain);
        e.ph = wrap(int'($atan2(real'(yv), real'(xv)) * 32768.0 / PI));
        e.ptol = (xv == 0 && yv == 0) ? 2 : 4;
        return e;
    endfunction

    // Monitor: values seen at the negedge are exactly what the next posedge acts on.
    always @(negedge clk) begin
        if (reset) begin
            q.delete();
            stall = 0;
        end else begin
            if (stall && out_valid) begin
                check("hold_magnitude", int'(magnitude), hold_mag, 0, 0);
                check("hold_phase", int'(phase), hold_ph, 0, 0);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_result: got out_valid with no pending sample at %0t", $time);
                end else begin
                    e_mon = q.pop_front();
                    check("magnitude", int'(magnitude), e_mon.mag, TOL_MAG, 0);
                    check("phase", int'(phase), e_mon.ph, e_mon.ptol, 1);
                end
            end
            if (in_valid && in_ready) q.push_back(model(int'(x_in), int'(y_in)));
            stall = out_valid && !out_ready;
            hold_mag = int'(magnitude);
            hold_ph = int'(phase);
        end
    end

    task automatic send(input int xv, input int yv);
        int n;
        in_valid = 1;
        x_in = SIZE_DATA'(xv);
        y_in = SIZE_DATA'(yv);
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: in_ready stayed 0, required 1");
        end
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 64) begin
            tests++;
            fails++;
            $display("FAIL out_timeout: out_valid stayed 0, required 1");
        end
    endtask

    task automatic run_dir(input string name, input int xv, input int yv, input int mag_c, input int ph, input int ptol);
        int n, m;
`ifdef CORDIC_GAIN_COMPENSATION_EN
        m = mag_c;
`else
        m = int'(mag_c * 1.646760);
`endif
        send(xv, yv);
        wait_out(n);
        check({name, "_latency"}, n, LAT, 0, 0);
        check({name, "_mag"}, int'(magnitude), m, TOL_MAG, 0);
        check({name, "_phase"}, int'(phase), ph, ptol, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        int n, xv, yv;
`ifndef CORDIC_GAIN_COMPENSATION_EN
        for (int k = 0; k < CORDIC_ITERATIONS; k++) gain = gain * $sqrt(1.0 + 2.0 ** (-2.0 * k));
`endif
        #1 reset = 1;
        #1;
        check("rst_in_ready", int'(in_ready), 0, 0, 0);
        check("rst_out_valid", int'(out_valid), 0, 0, 0);
        check("rst_magnitude", int'(magnitude), 0, 0, 0);
        check("rst_phase", int'(phase), 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 reset = 0;
        check("in_ready_before_clk", int'(in_ready), 0, 0, 0);
        @(posedge clk); #1;
        check("in_ready_after_clk", int'(in_ready), 1, 0, 0);

        run_dir("pos_x", 16384, 0, 16384, 0, 4);
        run_dir("pos_y", 0, 16384, 16384, 16384, 4);
        run_dir("q3_diag", -16384, -16384, 23170, -24576, 4);
        run_dir("neg_x_pi", -16384, 0, 16384, -32768, 4);
        run_dir("zero", 0, 0, 0, 0, 2);
        run_dir("min_x", -32768, 0, 32768, -32768, 4);
        run_dir("min_xy", -32768, -32768, 46341, -24576, 4);

        // Back-pressure: result must hold, new input ignored, then IDLE right after release
        out_ready = 0;
        send(12000, -5000);
        wait_out(n);
        for (int k = 0; k < 10; k++) begin
            in_valid = (k >= 3 && k < 6);
            x_in = 16'sd100;
            y_in = 16'sd200;
            @(posedge clk); #1;
            check("stall_in_ready", int'(in_ready), 0, 0, 0);
            check("stall_out_valid", int'(out_valid), 1, 0, 0);
        end
        in_valid = 0;
        out_ready = 1;
        @(posedge clk); #1;
        check("release_out_valid", int'(out_valid), 0, 0, 0);
        check("release_in_ready", int'(in_ready), 1, 0, 0);
        repeat (LAT + 3) @(posedge clk);
        #1 check("ignored_input_no_result", int'(out_valid), 0, 0, 0);

        // Reset mid-ITERATE and mid-DONE
        send(20000, 7000);
        repeat (5) @(posedge clk);
        #1 reset = 1;
        #1;
        check("abort_iter_out_valid", int'(out_valid), 0, 0, 0);
        check("abort_iter_in_ready", int'(in_ready), 0, 0, 0);
        @(posedge clk); #1 reset = 0;
        out_ready = 0;
        send(-9000, 15000);
        wait_out(n);
        reset = 1;
        #1;
        check("abort_done_out_valid", int'(out_valid), 0, 0, 0);
        check("abort_done_magnitude", int'(magnitude), 0, 0, 0);
        @(posedge clk); #1 reset = 0;
        out_ready = 1;
        run_dir("neg_y", 0, -16384, 16384, -16384, 4);

        // Random traffic with back-to-back inputs and random output stalls
        fork
            begin
                for (int k = 0; k < 1000; k++) begin
                    do begin
                        xv = int'($urandom_range(0, 65535)) - 32768;
                        yv = int'($urandom_range(0, 65535)) - 32768;
                    end while (real'(xv) * real'(xv) + real'(yv) * real'(yv) < 16384.0 * 16384.0);
                    send(xv, yv);
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1;
            end
        join
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_pending", q.size(), 0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1);
    end
endmodule
